vic_responder: RTL and testbench

//  Vectored-interrupt responder: target side of the CPU interrupt-vector handshake (virq/istb/ivec/iack).

---
 rtl/vic_responder.sv | 105 ++++++++++
 tb/tb_vic_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vic_responder.sv
// rtl/vic_responder.sv - vectored-interrupt responder, CPU side of the virq/istb/ivec/iack handshake
// Fixed-priority arbitration over NREQ request levels, one grant pulse per handshake.
module vic_responder #(
  parameter int          NREQ     = 8,
  parameter logic [15:0] DFLT_VEC = 16'o000
) (
  input  logic                 clk_p,
  input  logic                 rst_n,
  input  logic                 init,
  input  logic [NREQ-1:0]      irq_req,
  input  logic [NREQ-1:0]      irq_mask,
  input  logic [NREQ*16-1:0]   irq_vec,
  output logic [NREQ-1:0]      irq_ack,
  output logic                 virq,
  input  logic                 istb,
  output logic [15:0]          ivec,
  output logic                 iack
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEL, ACK, DROP} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   winner;
  logic              hit;
  logic [NREQ-1:0]   pend;
  logic [15:0]       sel_vec;
  logic [NREQ-1:0]   idx_onehot;

  assign pend = irq_req & irq_mask;

  // Scan from the top down so the lowest pending index wins.
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend[i]) winner = IDXW'(i);
    end
  end

  always_comb begin
    sel_vec    = '0;
    idx_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == IDXW'(i)) begin
        sel_vec       = irq_vec[16*i +: 16];
        idx_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      virq    <= 1'b0;
      iack    <= 1'b0;
      ivec    <= '0;
      irq_ack <= '0;
      idx     <= '0;
      hit     <= 1'b0;
    end else if (init) begin
      state   <= IDLE;
      virq    <= 1'b0;
      iack    <= 1'b0;
      ivec    <= '0;
      irq_ack <= '0;
      idx     <= '0;
      hit     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          virq    <= |pend;
          iack    <= 1'b0;
          irq_ack <= '0;
          if (istb) begin
            hit <= |pend;
            if (|pend) idx <= winner;
            state <= SEL;
          end
        end
        SEL: begin
          virq    <= 1'b0;
          ivec    <= hit ? sel_vec : DFLT_VEC;
          irq_ack <= hit ? idx_onehot : '0;
          state   <= ACK;
        end
        ACK: begin
          virq    <= 1'b0;
          irq_ack <= '0;
          iack    <= istb;
          if (!istb) state <= DROP;
        end
        default: begin
          // Dead cycle lets the granted peripheral drop its request first.
          virq    <= 1'b0;
          iack    <= 1'b0;
          irq_ack <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vic_responder.sv
// tb/tb_vic_responder.sv - scoreboard bench for vic_responder
module tb_vic_responder;

  localparam logic [15:0] DFLT = 16'o774;

  logic         clk_p = 1'b0;
  logic         rst_n;
  logic         init;
  logic [7:0]   irq_req;
  logic [7:0]   irq_mask;
  logic [127:0] irq_vec;
  logic [7:0]   irq_ack;
  logic         virq;
  logic         istb;
  logic [15:0]  ivec;
  logic         iack;

  typedef struct {
    logic [15:0] vec;
    logic [7:0]  ack;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  vic_responder #(.NREQ(8), .DFLT_VEC(DFLT)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .init(init),
    .irq_req(irq_req), .irq_mask(irq_mask), .irq_vec(irq_vec),
    .irq_ack(irq_ack), .virq(virq), .istb(istb), .ivec(ivec), .iack(iack)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick;
    @(posedge clk_p);
    #1;
  endtask

  task automatic set_vec(input int ch, input logic [15:0] v);
    irq_vec[16*ch +: 16] = v;
  endtask

  task automatic push_exp(input logic [15:0] v, input logic [7:0] a);
    exp_t e;
    e.vec = v;
    e.ack = a;
    sb.push_back(e);
  endtask

  // Raise istb, wait for iack, compare against the scoreboard head, hold, release.
  task automatic run_handshake(input string name, input int hold);
    int          cyc = 0;
    int          pulses = 0;
    int          unstable = 0;
    logic [7:0]  ack_or = '0;
    logic [15:0] v0;
    exp_t        e;
    istb = 1'b1;
    while (iack !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
      if (irq_ack !== 8'h00) begin pulses++; ack_or |= irq_ack; end
    end
    n_cmp++;
    if (iack !== 1'b1) begin n_err++; $display("FAIL %s iack_timeout: got %b want 1", name, iack); end
    n_cmp++;
    if (cyc !== 3) begin n_err++; $display("FAIL %s latency: got %0d want 3", name, cyc); end
    n_cmp++;
    if (virq !== 1'b0) begin n_err++; $display("FAIL %s virq_busy: got %b want 0", name, virq); end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (ivec !== e.vec) begin n_err++; $display("FAIL %s ivec: got %o want %o", name, ivec, e.vec); end
      n_cmp++;
      if (ack_or !== e.ack) begin n_err++; $display("FAIL %s irq_ack: got %h want %h", name, ack_or, e.ack); end
    end
    v0 = ivec;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (iack !== 1'b1 || ivec !== v0) unstable++;
      if (irq_ack !== 8'h00) begin pulses++; ack_or |= irq_ack; end
    end
    n_cmp++;
    if (unstable !== 0) begin n_err++; $display("FAIL %s hold_stable: got %0d bad cycles want 0", name, unstable); end
    n_cmp++;
    if (pulses !== ((e.ack != 0) ? 1 : 0)) begin
      n_err++; $display("FAIL %s pulse_count: got %0d want %0d", name, pulses, (e.ack != 0) ? 1 : 0);
    end
    istb = 1'b0;
    tick();
    n_cmp++;
    if (iack !== 1'b0) begin n_err++; $display("FAIL %s iack_drop: got %b want 0", name, iack); end
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; init = 1'b0; istb = 1'b0;
    irq_req = 8'hFF; irq_mask = 8'hFF; irq_vec = '0;
    tick(); tick();
    n_cmp++;
    if (virq !== 1'b0) begin n_err++; $display("FAIL reset virq: got %b want 0", virq); end
    n_cmp++;
    if (iack !== 1'b0) begin n_err++; $display("FAIL reset iack: got %b want 0", iack); end
    n_cmp++;
    if (ivec !== 16'h0) begin n_err++; $display("FAIL reset ivec: got %o want 0", ivec); end
    n_cmp++;
    if (irq_ack !== 8'h00) begin n_err++; $display("FAIL reset irq_ack: got %h want 00", irq_ack); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (virq !== 1'b1) begin n_err++; $display("FAIL reset virq_after: got %b want 1", virq); end
    irq_req = 8'h00;
    tick();
  endtask

  task automatic test_single;
    set_vec(3, 16'o060);
    irq_req = 8'h08;
    tick();
    n_cmp++;
    if (virq !== 1'b1) begin n_err++; $display("FAIL single virq: got %b want 1", virq); end
    push_exp(16'o060, 8'h08);
    run_handshake("single", 0);
    irq_req = 8'h00;
    tick();
    n_cmp++;
    if (virq !== 1'b0) begin n_err++; $display("FAIL single virq_idle: got %b want 0", virq); end
  endtask

  task automatic test_priority;
    set_vec(2, 16'o100);
    set_vec(5, 16'o300);
    irq_req = 8'h24;
    push_exp(16'o100, 8'h04);
    run_handshake("prio_first", 0);
    irq_req = 8'h20;
    push_exp(16'o300, 8'h20);
    run_handshake("prio_second", 0);
    irq_req = 8'h00;
    tick();
  endtask

  task automatic test_mask;
    set_vec(0, 16'o010);
    irq_req = 8'h01; irq_mask = 8'hFE;
    tick(); tick();
    n_cmp++;
    if (virq !== 1'b0) begin n_err++; $display("FAIL mask virq: got %b want 0", virq); end
    push_exp(DFLT, 8'h00);
    run_handshake("mask_passive", 0);
    irq_req = 8'h00; irq_mask = 8'hFF;
    tick();
  endtask

  task automatic test_long_strobe;
    set_vec(1, 16'o040);
    irq_req = 8'h02;
    push_exp(16'o040, 8'h02);
    run_handshake("long_strobe", 20);
    irq_req = 8'h00;
    tick();
  endtask

  task automatic test_init;
    set_vec(6, 16'o200);
    irq_req = 8'h40;
    istb = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (iack !== 1'b1) begin n_err++; $display("FAIL init iack_before: got %b want 1", iack); end
    init = 1'b1;
    istb = 1'b0;
    tick();
    n_cmp++;
    if (iack !== 1'b0) begin n_err++; $display("FAIL init iack: got %b want 0", iack); end
    n_cmp++;
    if (ivec !== 16'h0) begin n_err++; $display("FAIL init ivec: got %o want 0", ivec); end
    n_cmp++;
    if (virq !== 1'b0) begin n_err++; $display("FAIL init virq: got %b want 0", virq); end
    init = 1'b0;
    tick();
    n_cmp++;
    if (virq !== 1'b1) begin n_err++; $display("FAIL init virq_reraise: got %b want 1", virq); end
    push_exp(16'o200, 8'h40);
    run_handshake("after_init", 0);
    irq_req = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_long_strobe();
    test_init();
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
